// File: rtl/vend_sequencer_pkg.sv
// rtl/vend_sequencer_pkg.sv - shared state encodings and coin values for the vending sequencer
// Purpose : common definitions imported by the sequencer top, its timer and the bench.
// Contents: state_t (IDLE/ACCUM/VEND/CHANGE), coin values in nickels.
package vend_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  localparam int COIN_N = 1;
  localparam int COIN_D = 2;

endpackage

// File: rtl/vend_sequencer_idle_timer.sv
// rtl/vend_sequencer_idle_timer.sv - saturating inactivity counter for the ACCUM state
// Purpose : counts enabled cycles and flags when the count sits at TIMEOUT-1.
// Ports   : clk, rst (async, active high)
//           clr_i    - return count to zero (wins over en_i)
//           en_i     - advance count by one, saturating at TIMEOUT-1
//           expire_o - count equals TIMEOUT-1
module vend_idle_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == LAST);

endmodule

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - coin credit accumulator, vend handshake and nickel change payout
// Purpose : accumulates nickel/dime credit, requests a vend, pays change one nickel at a time,
//           handles cancel, inactivity timeout and over-credit coin rejection.
// Ports   : clk, reset (async, active high)
//           N, D        - one-cycle coin pulses (nickel, dime)
//           cancel      - refund request
//           vend_ack    - dispenser done pulse
//           chg_ack     - hopper ejected one nickel pulse
//           vend_req    - high in VEND
//           chg_req     - high in CHANGE
//           coin_reject - one-cycle pulse, last coin returned
//           credit      - current credit in nickels
//           busy        - high in VEND or CHANGE
module vend_sequencer
  import vend_sequencer_pkg::*;
#(
  parameter int PRICE    = 3,
  parameter int MAX_CRED = 7,
  parameter int TIMEOUT  = 1000,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          N,
  input  logic          D,
  input  logic          cancel,
  input  logic          vend_ack,
  input  logic          chg_ack,
  output logic          vend_req,
  output logic          chg_req,
  output logic          coin_reject,
  output logic [CW-1:0] credit,
  output logic          busy
);

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_CRED);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          rej_q, rej_d;

  logic [CW-1:0] coin_v;
  logic [CW-1:0] cn;
  logic [CW-1:0] c_eff;
  logic [CW-1:0] rem;
  logic          both;
  logic          over;
  logic          coin_ok;
  logic          timeout_hit;
  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_expire;

  vend_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    rej_d       = 1'b0;
    coin_v      = '0;
    c_eff       = credit_q;
    rem         = credit_q - PRICE_C;
    coin_ok     = 1'b0;
    timeout_hit = 1'b0;

    // Two coins in one cycle cannot be credited unambiguously; both go back.
    both = N & D;
    if (N && !D) begin
      coin_v = CW'(COIN_N);
    end else if (D && !N) begin
      coin_v = CW'(COIN_D);
    end
    cn   = credit_q + coin_v;
    over = (cn > MAX_C);

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (both || over) begin
          rej_d = 1'b1;
        end else begin
          c_eff = cn;
        end
        coin_ok     = (coin_v != '0) && !over;
        credit_d    = c_eff;
        timeout_hit = (state_q == ST_ACCUM) && tmr_expire;
        if ((cancel || timeout_hit) && (c_eff != '0)) begin
          state_d = ST_CHANGE;
        end else if (c_eff >= PRICE_C) begin
          state_d = ST_VEND;
        end else if (c_eff != '0) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VEND: begin
        rej_d = N | D;
        if (vend_ack) begin
          credit_d = rem;
          state_d  = (rem != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        rej_d = N | D;
        // Zero credit here can only come from a corrupted register; just leave.
        if (credit_q == '0) begin
          state_d = ST_IDLE;
        end else if (chg_ack) begin
          credit_d = credit_q - ONE_C;
          if (credit_q == ONE_C) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase

    // Idle time restarts on every accepted coin and whenever ACCUM is not held.
    tmr_clr = (state_q != ST_ACCUM) || (state_d != ST_ACCUM) || coin_ok;
    tmr_en  = !tmr_clr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      rej_q    <= rej_d;
    end
  end

  assign vend_req    = (state_q == ST_VEND);
  assign chg_req     = (state_q == ST_CHANGE);
  assign busy        = (state_q == ST_VEND) || (state_q == ST_CHANGE);
  assign coin_reject = rej_q;
  assign credit      = credit_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - directed bench for the vending sequencer
module tb_vend_sequencer;

  logic       clk;
  logic       reset;
  logic       n_i, d_i, cancel_i, vack_i, cack_i;
  logic       vreq_o, creq_o, rej_o, busy_o;
  logic [3:0] cred_o;

  logic       bn_i, bd_i, bvack_i, bzero;
  logic       bvreq_o, bcreq_o, brej_o, bbusy_o;
  logic [3:0] bcred_o;

  int vectors;
  int miscompares;

  vend_sequencer #(.PRICE(3), .MAX_CRED(7), .TIMEOUT(8), .CW(4)) dut_a (
    .clk(clk), .reset(reset), .N(n_i), .D(d_i), .cancel(cancel_i),
    .vend_ack(vack_i), .chg_ack(cack_i), .vend_req(vreq_o), .chg_req(creq_o),
    .coin_reject(rej_o), .credit(cred_o), .busy(busy_o)
  );

  vend_sequencer #(.PRICE(7), .MAX_CRED(7), .TIMEOUT(1000), .CW(4)) dut_b (
    .clk(clk), .reset(reset), .N(bn_i), .D(bd_i), .cancel(bzero),
    .vend_ack(bvack_i), .chg_ack(bzero), .vend_req(bvreq_o), .chg_req(bcreq_o),
    .coin_reject(brej_o), .credit(bcred_o), .busy(bbusy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic n, input logic d, input logic c, input logic va, input logic ca);
    @(negedge clk);
    n_i = n; d_i = d; cancel_i = c; vack_i = va; cack_i = ca;
    @(posedge clk);
    #1;
  endtask

  task automatic bcyc(input logic n, input logic d, input logic va);
    @(negedge clk);
    bn_i = n; bd_i = d; bvack_i = va;
    n_i = 1'b0; d_i = 1'b0; cancel_i = 1'b0; vack_i = 1'b0; cack_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] c, input logic vr,
                       input logic cr, input logic rj, input logic bz);
    chk({tag, "_credit"}, 32'(cred_o), 32'(c));
    chk({tag, "_vend_req"}, 32'(vreq_o), 32'(vr));
    chk({tag, "_chg_req"}, 32'(creq_o), 32'(cr));
    chk({tag, "_reject"}, 32'(rej_o), 32'(rj));
    chk({tag, "_busy"}, 32'(busy_o), 32'(bz));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    n_i = 0; d_i = 0; cancel_i = 0; vack_i = 0; cack_i = 0;
    bn_i = 0; bd_i = 0; bvack_i = 0; bzero = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 4'd0, 0, 0, 0, 0);
    chk("reset_b_credit", 32'(bcred_o), 0);
    @(negedge clk);
    reset = 1'b0;

    // Exact price: N then D, ack after 3 cycles in VEND
    cyc(1, 0, 0, 0, 0); chk_a("t1_n", 4'd1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); chk_a("t1_d", 4'd3, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 0); chk_a("t1_cancel_in_vend", 4'd3, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0); chk_a("t1_wait", 4'd3, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 0); chk_a("t1_ack", 4'd0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0); chk_a("t1_idle", 4'd0, 0, 0, 0, 0);

    // Overpay: D, D -> 4 nickels, one nickel change
    cyc(0, 1, 0, 0, 0); chk_a("t2_d1", 4'd2, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); chk_a("t2_d2", 4'd4, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 0); chk_a("t2_vack", 4'd1, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1); chk_a("t2_cack", 4'd0, 0, 0, 0, 0);

    // Simultaneous coins and coin during VEND
    cyc(1, 0, 0, 0, 0); chk_a("t3_n", 4'd1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0); chk_a("t3_nd", 4'd1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0); chk_a("t3_nd_after", 4'd1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); chk_a("t3_d", 4'd3, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 0); chk_a("t3_coin_vend", 4'd3, 1, 0, 1, 1);
    cyc(0, 0, 0, 1, 0); chk_a("t3_vack", 4'd0, 0, 0, 0, 0);

    // Over-credit on the PRICE=7 instance
    bcyc(0, 1, 0); chk("t3b_d1", 32'(bcred_o), 2);
    bcyc(0, 1, 0); chk("t3b_d2", 32'(bcred_o), 4);
    bcyc(0, 1, 0); chk("t3b_d3", 32'(bcred_o), 6);
    chk("t3b_d3_rej", 32'(brej_o), 0);
    bcyc(0, 1, 0); chk("t3b_d4_credit", 32'(bcred_o), 6);
    chk("t3b_d4_rej", 32'(brej_o), 1);
    chk("t3b_d4_vreq", 32'(bvreq_o), 0);
    bcyc(1, 0, 0); chk("t3b_n_credit", 32'(bcred_o), 7);
    chk("t3b_n_rej", 32'(brej_o), 0);
    chk("t3b_n_vreq", 32'(bvreq_o), 1);
    bcyc(0, 0, 1); chk("t3b_vack_credit", 32'(bcred_o), 0);
    chk("t3b_vack_busy", 32'(bbusy_o), 0);
    bcyc(0, 0, 0);

    // Cancel, coin during CHANGE, cancel with no credit
    cyc(1, 0, 0, 0, 0); chk_a("t4_n", 4'd1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); chk_a("t4_cancel", 4'd1, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 0); chk_a("t4_coin_change", 4'd1, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 1); chk_a("t4_cack", 4'd0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); chk_a("t4_cancel_zero", 4'd0, 0, 0, 0, 0);

    // Inactivity timeout: CHANGE exactly 8 cycles after credit becomes 1
    cyc(1, 0, 0, 0, 0); chk_a("t4_to_n", 4'd1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("t4_to_wait_chg", 32'(creq_o), 0);
    end
    cyc(0, 0, 0, 0, 0); chk_a("t4_to_fire", 4'd1, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1); chk_a("t4_to_cack", 4'd0, 0, 0, 0, 0);

    // Reset while paying change with credit 2
    cyc(0, 1, 0, 0, 0); chk_a("t5_d", 4'd2, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); chk_a("t5_cancel", 4'd2, 0, 1, 0, 1);
    @(negedge clk);
    cancel_i = 1'b0;
    reset = 1'b1;
    #1;
    chk_a("t5_async_rst", 4'd0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_a("t5_rst_cycle", 4'd0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 0, 1, 0); chk_a("t5_spur_vack", 4'd0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1); chk_a("t5_spur_cack", 4'd0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0); chk_a("t5_after_n", 4'd1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
